// File: rtl/nonce_collector.sv
// -----------------------------------------------------------------------------
// nonce_collector
//
// Two-slot result buffer in front of the SPI result formatter. Core 1 owns
// slot 1 and core 2 owns slot 2. A captured nonce is corrected for the core
// pipeline lag (raw - NONCE_OFFSET, modulo 2^32) and tagged with the chip ID.
// The formatter retires the oldest valid slot with result_ack.
//
// Ports
//   clk                 clock
//   reset_n             asynchronous active-low reset
//   chip_id             static chip ID, sampled when a slot captures
//   core1_found/_nonce  found pulse and raw nonce from hash core 1
//   core2_found/_nonce  found pulse and raw nonce from hash core 2
//   result_ack          retire the oldest valid slot (ignored when empty)
//   flush               clear both slots; drop_count is kept
//   nonce1_output       slot 1 word {chip_id, adjusted nonce}
//   nonce2_output       slot 2 word {chip_id, adjusted nonce}
//   nonce_mark          1 = slot 1 is the most recent capture
//   nonce_mark_counter  number of valid slots (0..2)
//   nonce_irq           high while any slot is valid
//   drop_count          saturating count of reports lost to a full slot
// -----------------------------------------------------------------------------
module nonce_collector #(
  parameter logic [31:0] NONCE_OFFSET = 32'd2,
  parameter int          CHIP_ID_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CHIP_ID_W-1:0]    chip_id,
  input  logic                    core1_found,
  input  logic [31:0]             core1_nonce,
  input  logic                    core2_found,
  input  logic [31:0]             core2_nonce,
  input  logic                    result_ack,
  input  logic                    flush,
  output logic [CHIP_ID_W+31:0]   nonce1_output,
  output logic [CHIP_ID_W+31:0]   nonce2_output,
  output logic                    nonce_mark,
  output logic [1:0]              nonce_mark_counter,
  output logic                    nonce_irq,
  output logic [7:0]              drop_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t state1_q, state2_q;
  slot_state_t state1_d, state2_d;

  // Per-cycle event strobes decoded from the current slot states.
  logic       valid1, valid2;
  logic       ret1, ret2;
  logic       cap1, cap2;
  logic       drop1, drop2;
  logic       next_valid1, next_valid2;
  logic       mark_d;
  logic [1:0] count_d;
  logic       irq_d;
  logic [7:0] drop_d;

  // Saturating add for the drop counter (0, 1 or 2 per cycle).
  function automatic logic [7:0] sat_add_drop(input logic [7:0] cnt,
                                              input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Pipeline-lag correction; wraps modulo 2^32 by construction.
  function automatic logic [31:0] adjust_nonce(input logic [31:0] raw);
    return raw - NONCE_OFFSET;
  endfunction

  // ---------------------------------------------------------------------------
  // Slot state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state1_q <= EMPTY;
      state2_q <= EMPTY;
    end else begin
      state1_q <= state1_d;
      state2_q <= state2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot next-state logic. A FULL slot that is retired and refilled in the
  // same cycle simply stays FULL.
  // ---------------------------------------------------------------------------
  always_comb begin
    state1_d = state1_q;
    unique case (state1_q)
      EMPTY: if (cap1) state1_d = FULL;
      FULL:  if (flush || (ret1 && !cap1)) state1_d = EMPTY;
      default: state1_d = EMPTY;
    endcase

    state2_d = state2_q;
    unique case (state2_q)
      EMPTY: if (cap2) state2_d = FULL;
      FULL:  if (flush || (ret2 && !cap2)) state2_d = EMPTY;
      default: state2_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Event decode: retire first, then capture; flush overrides both and
  // swallows found pulses without counting them as drops.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid1 = (state1_q == FULL);
    valid2 = (state2_q == FULL);
    ret1   = 1'b0;
    ret2   = 1'b0;
    cap1   = 1'b0;
    cap2   = 1'b0;
    drop1  = 1'b0;
    drop2  = 1'b0;

    if (!flush) begin
      if (result_ack) begin
        // With both valid, mark=1 means slot 1 is newer so slot 2 is oldest.
        if (valid1 && valid2) begin
          if (nonce_mark) ret2 = 1'b1;
          else            ret1 = 1'b1;
        end else if (valid1) begin
          ret1 = 1'b1;
        end else if (valid2) begin
          ret2 = 1'b1;
        end
      end

      cap1  = core1_found && (!valid1 || ret1);
      drop1 = core1_found && valid1 && !ret1;
      cap2  = core2_found && (!valid2 || ret2);
      drop2 = core2_found && valid2 && !ret2;
    end

    next_valid1 = !flush && ((valid1 && !ret1) || cap1);
    next_valid2 = !flush && ((valid2 && !ret2) || cap2);
    count_d     = {1'b0, next_valid1} + {1'b0, next_valid2};
    irq_d       = (count_d != 2'd0);

    // Simultaneous capture treats slot 1 as older (mark 0). After a retire
    // that leaves one slot, the mark simply names that slot. With nothing
    // left the mark keeps its last value.
    mark_d = nonce_mark;
    if (cap1 && cap2) begin
      mark_d = 1'b0;
    end else if (cap1) begin
      mark_d = 1'b1;
    end else if (cap2) begin
      mark_d = 1'b0;
    end else if ((ret1 || ret2) && (next_valid1 ^ next_valid2)) begin
      mark_d = next_valid1;
    end

    drop_d = sat_add_drop(drop_count, {1'b0, drop1} + {1'b0, drop2});
  end

  // ---------------------------------------------------------------------------
  // Slot data: written only on capture, so it is frozen while the slot is
  // FULL and left in place (only invalidated) when retired.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nonce1_output <= '0;
      nonce2_output <= '0;
    end else begin
      if (cap1) nonce1_output <= {chip_id, adjust_nonce(core1_nonce)};
      if (cap2) nonce2_output <= {chip_id, adjust_nonce(core2_nonce)};
    end
  end

  // ---------------------------------------------------------------------------
  // Registered flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nonce_mark         <= 1'b0;
      nonce_mark_counter <= 2'd0;
      nonce_irq          <= 1'b0;
      drop_count         <= 8'd0;
    end else begin
      nonce_mark         <= mark_d;
      nonce_mark_counter <= count_d;
      nonce_irq          <= irq_d;
      drop_count         <= drop_d;
    end
  end

endmodule

// File: tb/tb_nonce_collector.sv
module tb_nonce_collector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  chip_id;
  logic        core1_found, core2_found;
  logic [31:0] core1_nonce, core2_nonce;
  logic        result_ack, flush;
  logic [39:0] nonce1_output, nonce2_output;
  logic        nonce_mark;
  logic [1:0]  nonce_mark_counter;
  logic        nonce_irq;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  nonce_collector dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .chip_id            (chip_id),
    .core1_found        (core1_found),
    .core1_nonce        (core1_nonce),
    .core2_found        (core2_found),
    .core2_nonce        (core2_nonce),
    .result_ack         (result_ack),
    .flush              (flush),
    .nonce1_output      (nonce1_output),
    .nonce2_output      (nonce2_output),
    .nonce_mark         (nonce_mark),
    .nonce_mark_counter (nonce_mark_counter),
    .nonce_irq          (nonce_irq),
    .drop_count         (drop_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] cnt, input logic mark,
                         input logic [7:0] drop, input logic [39:0] s1, input logic [39:0] s2);
    chk({tag, " counter"}, 64'(nonce_mark_counter), 64'(cnt));
    chk({tag, " mark"},    64'(nonce_mark),         64'(mark));
    chk({tag, " irq"},     64'(nonce_irq),          64'(cnt != 2'd0));
    chk({tag, " drop"},    64'(drop_count),         64'(drop));
    chk({tag, " slot1"},   64'(nonce1_output),      64'(s1));
    chk({tag, " slot2"},   64'(nonce2_output),      64'(s2));
  endtask

  // One clock: inputs applied at the falling edge, outputs sampled 1 after rise.
  task automatic drive(input logic f1, input logic [31:0] n1, input logic f2,
                       input logic [31:0] n2, input logic ack, input logic fl);
    @(negedge clk);
    core1_found = f1; core1_nonce = n1;
    core2_found = f2; core2_nonce = n2;
    result_ack  = ack; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    core1_found = 0; core2_found = 0; result_ack = 0; flush = 0;
    core1_nonce = 0; core2_nonce = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an age-ordered queue of valid slots (oldest at front).
  // ---------------------------------------------------------------------------
  int          age_q[$];
  logic [39:0] m_data [1:2];
  logic        m_mark;
  int          m_drop;

  function automatic bit in_queue(input int s);
    foreach (age_q[i]) if (age_q[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    age_q.delete();
    m_data[1] = '0; m_data[2] = '0;
    m_mark = 1'b0; m_drop = 0;
  endtask

  task automatic model_step(input logic f1, input logic [31:0] n1, input logic f2,
                            input logic [31:0] n2, input logic ack, input logic fl);
    if (fl) begin
      age_q.delete();
    end else begin
      if (ack && age_q.size() > 0) void'(age_q.pop_front());
      if (f1) begin
        if (in_queue(1)) m_drop++;
        else begin age_q.push_back(1); m_data[1] = {chip_id, n1 - 32'd2}; end
      end
      if (f2) begin
        if (in_queue(2)) m_drop++;
        else begin age_q.push_back(2); m_data[2] = {chip_id, n2 - 32'd2}; end
      end
      if (m_drop > 255) m_drop = 255;
    end
    if (age_q.size() == 2)      m_mark = (age_q[1] == 1);
    else if (age_q.size() == 1) m_mark = (age_q[0] == 1);
  endtask

  task automatic random_run(input int cycles, input int found_div);
    logic f1, f2, ack, fl;
    logic [31:0] n1, n2;
    for (int c = 0; c < cycles; c++) begin
      f1  = ($urandom_range(0, found_div - 1) == 0);
      f2  = ($urandom_range(0, found_div - 1) == 0);
      ack = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 31) == 0);
      n1  = $urandom;
      n2  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      drive(f1, n1, f2, n2, ack, fl);
      model_step(f1, n1, f2, n2, ack, fl);
      chk_all($sformatf("rnd%0d", c), 2'(age_q.size()), m_mark, 8'(m_drop), m_data[1], m_data[2]);
    end
  endtask

  typedef struct {
    logic        f1;
    logic [31:0] n1;
    logic        f2;
    logic [31:0] n2;
    logic        ack;
    logic        fl;
    logic [1:0]  cnt;
    logic        mark;
    logic [7:0]  drop;
    logic [39:0] s1;
    logic [39:0] s2;
  } vec_t;

  vec_t vecs [19];

  initial begin
    vecs[0]  = '{1'b1, 32'h1000, 1'b0, 32'h0,   1'b0, 1'b0, 2'd1, 1'b1, 8'd0, 40'h5A00000FFE, 40'h0};
    vecs[1]  = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 2'd1, 1'b1, 8'd0, 40'h5A00000FFE, 40'h0};
    vecs[2]  = '{1'b0, 32'h0,    1'b1, 32'h1,   1'b0, 1'b0, 2'd2, 1'b0, 8'd0, 40'h5A00000FFE, 40'h5AFFFFFFFF};
    vecs[3]  = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 2'd1, 1'b0, 8'd0, 40'h5A00000FFE, 40'h5AFFFFFFFF};
    vecs[4]  = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 40'h5A00000FFE, 40'h5AFFFFFFFF};
    vecs[5]  = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 40'h5A00000FFE, 40'h5AFFFFFFFF};
    vecs[6]  = '{1'b0, 32'h0,    1'b1, 32'h20,  1'b0, 1'b0, 2'd1, 1'b0, 8'd0, 40'h5A00000FFE, 40'h5A0000001E};
    vecs[7]  = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 2'd1, 1'b0, 8'd0, 40'h5A00000FFE, 40'h5A0000001E};
    vecs[8]  = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 2'd1, 1'b0, 8'd0, 40'h5A00000FFE, 40'h5A0000001E};
    vecs[9]  = '{1'b1, 32'h30,   1'b0, 32'h0,   1'b0, 1'b0, 2'd2, 1'b1, 8'd0, 40'h5A0000002E, 40'h5A0000001E};
    vecs[10] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 2'd1, 1'b1, 8'd0, 40'h5A0000002E, 40'h5A0000001E};
    vecs[11] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 2'd0, 1'b1, 8'd0, 40'h5A0000002E, 40'h5A0000001E};
    vecs[12] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 2'd0, 1'b1, 8'd0, 40'h5A0000002E, 40'h5A0000001E};
    vecs[13] = '{1'b1, 32'h100,  1'b1, 32'h200, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0, 40'h5A000000FE, 40'h5A000001FE};
    vecs[14] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 2'd1, 1'b0, 8'd0, 40'h5A000000FE, 40'h5A000001FE};
    vecs[15] = '{1'b0, 32'h0,    1'b1, 32'h5,   1'b0, 1'b0, 2'd1, 1'b0, 8'd1, 40'h5A000000FE, 40'h5A000001FE};
    vecs[16] = '{1'b0, 32'h0,    1'b1, 32'h10,  1'b1, 1'b0, 2'd1, 1'b0, 8'd1, 40'h5A000000FE, 40'h5A0000000E};
    vecs[17] = '{1'b1, 32'h9,    1'b1, 32'h9,   1'b1, 1'b1, 2'd0, 1'b0, 8'd1, 40'h5A000000FE, 40'h5A0000000E};
    vecs[18] = '{1'b1, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 2'd1, 1'b1, 8'd1, 40'h5AFFFFFFFE, 40'h5A0000000E};

    chip_id = 8'h5A;
    reset_n = 1'b0;
    core1_found = 0; core2_found = 0; result_ack = 0; flush = 0;
    core1_nonce = 0; core2_nonce = 0;
    #2;
    chk_all("reset", 2'd0, 1'b0, 8'd0, 40'h0, 40'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].f1, vecs[i].n1, vecs[i].f2, vecs[i].n2, vecs[i].ack, vecs[i].fl);
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].mark, vecs[i].drop, vecs[i].s1, vecs[i].s2);
    end

    // Overflow: slot 1 stays FULL through 300 more found pulses.
    for (int i = 0; i < 300; i++) drive(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("overflow", 2'd1, 1'b1, 8'd255, 40'h5AFFFFFFFE, 40'h5A0000000E);

    // Ack and found in the same cycle: freed slot accepts the new nonce.
    drive(1'b1, 32'h77, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_all("ack_refill", 2'd1, 1'b1, 8'd255, 40'h5A00000075, 40'h5A0000000E);

    drive(1'b0, 32'h0, 1'b1, 32'hABC, 1'b0, 1'b0);
    chk_all("fill2", 2'd2, 1'b0, 8'd255, 40'h5A00000075, 40'h5A00000ABA);

    drive(1'b0, 32'h0, 1'b1, 32'h123, 1'b1, 1'b1);
    chk_all("flush_combo", 2'd0, 1'b0, 8'd255, 40'h5A00000075, 40'h5A00000ABA);

    // Asynchronous reset with both slots valid.
    drive(1'b1, 32'h11, 1'b1, 32'h22, 1'b0, 1'b0);
    chk_all("pre_reset", 2'd2, 1'b0, 8'd255, 40'h5A0000000F, 40'h5A00000020);
    @(negedge clk);
    core1_found = 0; core2_found = 0;
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_reset", 2'd0, 1'b0, 8'd0, 40'h0, 40'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized against the reference model.
    chip_id = 8'($urandom);
    model_reset();
    do_reset();
    random_run(1500, 2);
    chip_id = 8'($urandom);
    model_reset();
    do_reset();
    random_run(1500, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/nonce_collector.md
# nonce_collector

Two-slot result buffer sitting directly upstream of the SPI result formatter. It captures found-nonce reports from hash core 1 and hash core 2, corrects each nonce for core pipeline depth, and tags it with the chip ID. It presents both slots as `nonce1_output` / `nonce2_output` together with age-order (`nonce_mark`) and occupancy (`nonce_mark_counter`) flags. The formatter acknowledges each result after the host has read it.

## Interface
Parameters:
- `NONCE_OFFSET`, default 32'd2: value subtracted from the raw core nonce (core pipeline lag).
- `CHIP_ID_W`, default 8: chip ID width. Output word width is CHIP_ID_W+32 = 40.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `chip_id` in 8: static chip ID, sampled at capture.
- `core1_found` in 1: single-cycle pulse; `core1_nonce` is valid.
- `core1_nonce` in 32: raw nonce from core 1.
- `core2_found` in 1: single-cycle pulse; `core2_nonce` is valid.
- `core2_nonce` in 32: raw nonce from core 2.
- `result_ack` in 1: single-cycle pulse from the formatter; retire the oldest result.
- `flush` in 1: synchronous clear of both slots; `drop_count` is kept.
- `nonce1_output` out 40: slot 1 contents, {chip_id, adjusted nonce}.
- `nonce2_output` out 40: slot 2 contents.
- `nonce_mark` out 1: 1 = slot 1 holds the most recent capture; 0 = slot 2 is most recent, or tie.
- `nonce_mark_counter` out 2: number of valid slots (0, 1 or 2). Value 3 never occurs.
- `nonce_irq` out 1: high while `nonce_mark_counter` != 0.
- `drop_count` out 8: saturating count of reports lost because the target slot was full.

## Operation
- Slot ownership is fixed: core 1 writes only slot 1, and core 2 writes only slot 2.
- Adjusted nonce is `coreX_nonce - NONCE_OFFSET`, computed modulo 2^32. It wraps, for example 0x00000001 becomes 0xFFFFFFFF.
- Each slot has a state machine with states EMPTY and FULL:
  - EMPTY goes to FULL on the core's found pulse.
  - FULL goes to EMPTY on `result_ack` when this slot is the oldest valid slot, or on `flush`.
  - A found pulse while the slot is FULL and not being retired that cycle is discarded. `drop_count` increments by 1 and saturates at 255. Both cores dropping in the same cycle add 2, still saturating.
- Slot data never changes while the slot is FULL. The formatter reads it up to several cycles after sampling the flags.
- Oldest-slot selection:
  - count 1: the single valid slot.
  - count 2: slot 2 if `nonce_mark`=1, otherwise slot 1. This matches the formatter's read rule.
- `nonce_mark` update on capture:
  - slot 1 capture alone sets it to 1.
  - slot 2 capture alone sets it to 0.
  - simultaneous capture of both slots sets it to 0, so slot 1 is treated as older.
  - With count 1 after a retire, `nonce_mark` = (slot 1 valid).
  - With count 0 it holds its last value.
- Cycle ordering when events coincide: retire (ack) first, then capture. A slot freed by `result_ack` can accept that core's found pulse in the same cycle with no drop.
- `result_ack` with count 0 is ignored.
- `flush` has priority over ack and capture. Found pulses in the flush cycle are discarded and not counted as drops.
- All outputs are registered.

## Timing
- Reset value of every output is 0.
- Slot registers and state clear asynchronously on `reset_n` low. A capture in progress at reset is lost.
- Capture latency: found pulse at edge N, and the slot contents, counter, mark and irq are updated after edge N+1 (one cycle).
- Ack latency: `result_ack` at edge N, and the counter, mark and irq are updated after edge N+1. Slot data of the retired slot is not cleared, only invalidated.
- Counter and mark change only on capture, ack or flush edges. They are stable in all other cycles.
- Back-to-back found pulses on one core, with no ack, drop the second pulse.

## Test plan
- Reset, then one capture: `chip_id`=8'h5A and `core1_found` with `core1_nonce`=32'h00001000 → `nonce1_output`=40'h5A00000FFE, counter=1, mark=1, irq=1 one cycle later.
- Nonce wrap: `core2_nonce`=32'h00000001 → `nonce2_output`[31:0]=32'hFFFFFFFF, mark=0.
- Ordering: core 2 captures, then core 1 three cycles later → counter=2, mark=1. Ack → slot 2 retired, counter=1, mark=1. Ack → counter=0, irq=0. Extra ack → no change.
- Simultaneous capture of both cores → counter=2, mark=0. Ack retires slot 1, leaving mark=0 and counter=1.
- Overflow: slot 1 FULL and `core1_found` pulsed 300 times → slot data unchanged, `drop_count`=255. `result_ack` in the same cycle as `core1_found` → new nonce captured, no drop.
- `flush` coinciding with `core2_found` and `result_ack` → counter=0, irq=0, `drop_count` unchanged. Asserting `reset_n` low with counter=2 → all outputs 0 immediately.
